// File: rtl/timer_ctl_pkg.sv
// Timer controller shared definitions:
// FSM state encodings and mode constants.
`ifndef TIMER_CTL_PKG_SV
`define TIMER_CTL_PKG_SV
package timer_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } tstate_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage
`endif

// File: rtl/timer_irq.sv
// Sticky expiry flag with a saturating
// count of expiries missed while pending.
module timer_irq #(
  parameter int OW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          expire,
  input  logic          ack,
  output logic          irq,
  output logic [OW-1:0] overrun
);

  localparam logic [OW-1:0] OMAX = '1;

  logic hit;

  assign hit = expire & irq;

  always_ff @(posedge clock) begin
    if (reset) begin
      irq     <= 1'b0;
      overrun <= '0;
    end else begin
      irq <= expire | (irq & ~ack);
      // ack clears history, but a same-cycle miss still counts once
      if (ack)
        overrun <= hit ? OW'(1) : '0;
      else if (hit && overrun != OMAX)
        overrun <= overrun + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctl.sv
// Load/run sequencer driving an external
// countdown timer, with expiry interrupt.
module timer_ctl #(
  parameter int W  = 8,
  parameter int OW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  cfg_period,
  input  logic          cfg_periodic,
  input  logic          start,
  input  logic          stop,
  input  logic          ack,
  input  logic [W-1:0]  count,
  output logic [W-1:0]  value,
  output logic          put,
  output logic          busy,
  output logic          expire,
  output logic          irq,
  output logic [OW-1:0] overrun
);

  import timer_ctl_pkg::*;

  tstate_t      state, state_d;
  logic [W-1:0] per_q, per_d;
  logic         mode_q, mode_d;
  logic [W-1:0] value_d;
  logic         put_d;
  logic         exp_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      per_q  <= '0;
      mode_q <= MODE_ONESHOT;
      value  <= '0;
      put    <= 1'b0;
      busy   <= 1'b0;
      expire <= 1'b0;
    end else begin
      state  <= state_d;
      per_q  <= per_d;
      mode_q <= mode_d;
      value  <= value_d;
      put    <= put_d;
      busy   <= (state_d != IDLE);
      expire <= exp_d;
    end
  end

  // outputs are registered from the next-state decision
  always_comb begin
    state_d = state;
    per_d   = per_q;
    mode_d  = mode_q;
    value_d = '0;
    put_d   = 1'b0;
    exp_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      put_d   = 1'b1;
    end else if (start) begin
      per_d   = cfg_period;
      mode_d  = cfg_periodic;
      state_d = LOAD;
      put_d   = 1'b1;
      value_d = cfg_period;
    end else begin
      unique case (state)
        IDLE: state_d = IDLE;
        LOAD: state_d = RUN;
        RUN: begin
          if (count == '0) begin
            exp_d = 1'b1;
            unique case (mode_q)
              MODE_PERIODIC: begin
                state_d = LOAD;
                put_d   = 1'b1;
                value_d = per_q;
              end
              MODE_ONESHOT: state_d = IDLE;
              default:      state_d = IDLE;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  timer_irq #(
    .OW(OW)
  ) u_irq (
    .clock   (clock),
    .reset   (reset),
    .expire  (expire),
    .ack     (ack),
    .irq     (irq),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_timer_ctl.sv
// Directed bench for timer_ctl with a
// behavioural downstream countdown timer.
module tb_timer_ctl;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] cfg_period;
  logic       cfg_periodic;
  logic       start;
  logic       stop;
  logic       ack;
  logic [7:0] count;
  logic [7:0] value;
  logic       put;
  logic       busy;
  logic       expire;
  logic       irq;
  logic [1:0] overrun;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int puts = 0;
  int exp_at[$];

  timer_ctl #(
    .W  (8),
    .OW (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .ack          (ack),
    .count        (count),
    .value        (value),
    .put          (put),
    .busy         (busy),
    .expire       (expire),
    .irq          (irq),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (put)
      count <= value;
    else if (count != '0)
      count <= count - 8'd1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (expire) exp_at.push_back(cyc);
    if (put) puts++;
  endtask

  function automatic int expat(input int i);
    return (exp_at.size() > i) ? exp_at[i] : -1;
  endfunction

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  int s;
  int s2;

  initial begin
    reset        = 1'b1;
    cfg_period   = '0;
    cfg_periodic = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    ack          = 1'b0;
    tick();
    tick();
    check("rst put", put, 0);
    check("rst value", value, 0);
    check("rst busy", busy, 0);
    check("rst expire", expire, 0);
    check("rst irq", irq, 0);
    check("rst ovr", overrun, 0);
    reset = 1'b0;
    tick();

    // one-shot, period 5
    cfg_period   = 8'd5;
    cfg_periodic = 1'b0;
    exp_at.delete();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("os put", put, 1);
    check("os value", value, 5);
    tick();
    check("os count", count, 5);
    check("os busy", busy, 1);
    repeat (7) tick();
    check("os busy end", busy, 0);
    check("os irq", irq, 1);
    repeat (3) tick();
    check("os nexp", exp_at.size(), 1);
    check("os exp0", expat(0) - s, 8);
    do_ack();
    check("os ack irq", irq, 0);

    // periodic, period 3
    cfg_period   = 8'd3;
    cfg_periodic = 1'b1;
    exp_at.delete();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) begin
      tick();
      if (cyc - s == 7)  check("pr cnt3", count, 3);
      if (cyc - s == 8)  check("pr cnt2", count, 2);
      if (cyc - s == 10) check("pr cnt0", count, 0);
    end
    check("pr nexp", exp_at.size(), 3);
    check("pr exp0", expat(0) - s, 6);
    check("pr exp1", expat(1) - s, 11);
    check("pr exp2", expat(2) - s, 16);
    check("pr irq", irq, 1);
    check("pr ovr", overrun, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("pr stop put", put, 1);
    check("pr stop val", value, 0);
    check("pr stop busy", busy, 0);
    repeat (10) tick();
    check("pr after stop", exp_at.size(), 3);
    do_ack();
    check("pr ack irq", irq, 0);
    check("pr ack ovr", overrun, 0);

    // periodic, period 0
    cfg_period   = 8'd0;
    cfg_periodic = 1'b1;
    exp_at.delete();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("p0 nexp", exp_at.size(), 3);
    check("p0 exp0", expat(0) - s, 3);
    check("p0 exp1", expat(1) - s, 5);
    check("p0 exp2", expat(2) - s, 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("p0 stop put", put, 1);
    check("p0 stop val", value, 0);
    repeat (6) tick();
    check("p0 after stop", exp_at.size(), 3);
    do_ack();

    // restart mid-run, config change ignored
    cfg_period   = 8'd5;
    cfg_periodic = 1'b0;
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("rs cnt2", count, 2);
    cfg_period = 8'd7;
    exp_at.delete();
    s2 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_period   = 8'd2;
    cfg_periodic = 1'b1;
    check("rs put", put, 1);
    check("rs value", value, 7);
    repeat (12) tick();
    check("rs nexp", exp_at.size(), 1);
    check("rs exp0", expat(0) - s2, 10);
    check("rs busy", busy, 0);
    do_ack();

    // overrun saturation, ack with expiry
    cfg_period   = 8'd0;
    cfg_periodic = 1'b1;
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("ov irq", irq, 1);
    check("ov sat", overrun, 3);
    tick();
    check("ov expire", expire, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ov ack irq", irq, 1);
    check("ov ack ovr", overrun, 1);
    check("ov busy", busy, 1);

    // reset with start while running
    reset      = 1'b1;
    start      = 1'b1;
    cfg_period = 8'd6;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rr put", put, 0);
    check("rr value", value, 0);
    check("rr busy", busy, 0);
    check("rr expire", expire, 0);
    check("rr irq", irq, 0);
    check("rr ovr", overrun, 0);
    exp_at.delete();
    puts = 0;
    repeat (12) tick();
    check("rr nexp", exp_at.size(), 0);
    check("rr nput", puts, 0);
    check("rr idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
